// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the CPU-side load/store unit:
// access sizes, FSM encodings and the big-endian lane order.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Byte offset 0 is the most significant lane of a big-endian word.
    function automatic logic [4:0] be_lane_lsb(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a big-endian memory word and right-justified
// CPU data: load extraction/extension and store byte enables with replicated lane data.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] raw_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        load_data = '0;
        byte_en   = '0;
        lane_data = '0;
        sel_byte  = raw_word[be_lane_lsb(addr_lo) +: 8];
        sel_half  = addr_lo[1] ? raw_word[15:0] : raw_word[31:16];
        // byte_en[k] selects byte offset k within the word
        case (size)
            SZ_BYTE: begin
                load_data        = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
                byte_en[addr_lo] = 1'b1;
                lane_data        = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                load_data = raw_word;
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                load_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: big-endian byte array behind
// valid/ready request and response channels with a configurable wait-state count.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        write_q, uns_q, err_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        accept, do_access, acc_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_write, cur_uns;
    logic [32:0] end_addr;
    logic [31:0] raw_word, load_data, lane_data;
    logic [3:0]  byte_en;

    assign req_ready = rst & (state_q == S_IDLE);
    assign accept    = req_valid & req_ready;

    // With zero latency the access happens on the accept edge, before capture.
    assign cur_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;
    assign cur_size  = (state_q == S_IDLE) ? req_size     : size_q;
    assign cur_write = (state_q == S_IDLE) ? req_write    : write_q;
    assign cur_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;

    assign do_access = ((state_q == S_WAIT) && (cnt_q == LAST_CNT)) || (accept && (LATENCY == 0));

    assign end_addr = {1'b0, cur_addr} + 33'(size_bytes(cur_size)) - 33'd1;
    assign acc_err  = (cur_size == SZ_ILL)
                   || ((cur_size == SZ_HALF) && cur_addr[0])
                   || ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00))
                   || (end_addr >= 33'(MEM_BYTES));

    assign raw_word = {mem[{cur_addr[AW-1:2], 2'b00}], mem[{cur_addr[AW-1:2], 2'b01}],
                       mem[{cur_addr[AW-1:2], 2'b10}], mem[{cur_addr[AW-1:2], 2'b11}]};

    mem_lane_align u_align (
        .size        (cur_size),
        .addr_lo     (cur_addr[1:0]),
        .is_unsigned (cur_uns),
        .raw_word    (raw_word),
        .wdata       (cur_wdata),
        .load_data   (load_data),
        .byte_en     (byte_en),
        .lane_data   (lane_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                write_q <= req_write;
                uns_q   <= req_unsigned;
            end
            if (do_access) begin
                rdata_q <= (acc_err || cur_write) ? 32'd0 : load_data;
                err_q   <= acc_err;
            end
        end
    end

    // The array is deliberately outside reset so committed stores survive it.
    always_ff @(posedge clk) begin
        if (do_access && !acc_err && cur_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[{cur_addr[AW-1:2], 2'(k)}] <= lane_data[be_lane_lsb(2'(k)) +: 8];
                end
            end
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: two responders (LATENCY 2 and 0) against a byte-array model.
module tb_data_mem_responder;

    localparam int MEMB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;

    logic        v0, v1, rr0, rr1, rv0, rv1, re0, re1;
    logic        p0, p1;
    logic [31:0] rd0, rd1;
    logic        r_ready, r_valid, r_err;
    logic [31:0] r_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [2][MEMB];

    always #5 clk = ~clk;

    assign v0 = req_valid & ~sel;
    assign v1 = req_valid & sel;
    assign p0 = resp_ready & ~sel;
    assign p1 = resp_ready & sel;
    assign r_ready = sel ? rr1 : rr0;
    assign r_valid = sel ? rv1 : rv0;
    assign r_rdata = sel ? rd1 : rd0;
    assign r_err   = sel ? re1 : re0;

    data_mem_responder #(.MEM_BYTES(MEMB), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rr0), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(p0), .resp_rdata(rd0),
        .resp_err(re0)
    );

    data_mem_responder #(.MEM_BYTES(MEMB), .LATENCY(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rr1), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(p1), .resp_rdata(rd1),
        .resp_err(re1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: access computed straight from the byte-array rules.
    task automatic model_access(input int s, input bit wr, input int size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit er);
        longint la, nb, v;
        la = longint'(addr);
        nb = longint'(1) << size;
        er = (size == 3) || ((la % nb) != 0) || (la + nb > MEMB);
        rd = '0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mdl[s][la + i] = 8'(wdata >> (8 * (nb - 1 - i)));
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = (v << 8) | longint'(mdl[s][la + i]);
                if (!uns && nb < 4 && v[8 * nb - 1]) v = v - (longint'(1) << (8 * nb));
                rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input bit s, input bit wr, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] got);
        logic [31:0] exp_rd;
        bit exp_er;
        int k;
        model_access(int'(s), wr, int'(size), uns, addr, wdata, exp_rd, exp_er);
        @(negedge clk);
        sel = s; req_write = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check("ready_idle", 32'(r_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        req_write = 1'($urandom); req_unsigned = 1'($urandom);
        k = 1;
        while (!r_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("latency", k, s ? 32'd1 : 32'd3);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(r_valid), 32'd1);
            check("hold_ready", 32'(r_ready), 32'd0);
            check("hold_rdata", r_rdata, exp_rd);
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        got = r_rdata;
        check("resp_valid", 32'(r_valid), 32'd1);
        check("rdata", r_rdata, exp_rd);
        check("err", 32'(r_err), 32'(exp_er));
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after", {30'd0, r_valid, r_ready}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, ra, dummy;
        logic [1:0] rs;
        bit dummy_er;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < MEMB; a++) mdl[s][a] = 8'd0;

        @(negedge clk);
        check("rst_ready", {30'd0, rr1, rr0}, 32'd0);
        check("rst_valid", {30'd0, rv1, rv0}, 32'd0);
        check("rst_rdata", rd0 | rd1, 32'd0);
        check("rst_err", {30'd0, re1, re0}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {30'd0, rr1, rr0}, 32'd3);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < MEMB; a += 4) txn(1'(s), 1'b1, 2'd2, 1'b0, 32'(a), 32'd0, 0, got);

        // Reset during WAIT drops the uncommitted store.
        @(negedge clk);
        sel = 1'b0; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10;
        req_wdata = 32'hCAFEBABE; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(r_valid), 32'd0);
        check("midrst_ready", 32'(r_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ready", 32'(r_ready), 32'd1);
        check("rel_valid", 32'(r_valid), 32'd0);
        txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got);
        check("dropped_store", got, 32'd0);

        // Reset while RESP keeps the committed store but drops the response.
        model_access(0, 1'b1, 2, 1'b0, 32'h18, 32'h11223344, dummy, dummy_er);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h18; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("resp_before_rst", 32'(r_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("resp_dropped", 32'(r_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h18, 32'd0, 0, got);
        check("kept_store", got, 32'h11223344);

        for (int s = 0; s < 2; s++) begin
            txn(1'(s), 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 0, got);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, got);
            check("word_ld", got, 32'hDEADBEEF);
            txn(1'(s), 1'b0, 2'd0, 1'b1, 32'h20, 32'd0, 0, got);
            check("byte0", got, 32'h000000DE);
            txn(1'(s), 1'b0, 2'd0, 1'b0, 32'h23, 32'd0, 0, got);
            check("byte_s", got, 32'hFFFFFFEF);
            txn(1'(s), 1'b0, 2'd0, 1'b1, 32'h23, 32'd0, 0, got);
            check("byte_u", got, 32'h000000EF);
            txn(1'(s), 1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 0, got);
            check("half_s", got, 32'hFFFFDEAD);
            txn(1'(s), 1'b1, 2'd0, 1'b0, 32'h21, 32'hAAAAAA55, 0, got);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, got);
            check("byte_st", got, 32'hDE55BEEF);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 0, got);
            txn(1'(s), 1'b1, 2'd1, 1'b0, 32'h31, 32'h1234, 0, got);
            txn(1'(s), 1'b1, 2'd3, 1'b0, 32'h40, 32'h5678, 0, got);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h3FE, 32'd0, 0, got);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, got);
            check("err_untouched", got, 32'd0);
            txn(1'(s), 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 5, got);
            check("hold_word", got, 32'hDE55BEEF);
        end

        for (int n = 0; n < 300; n++) begin
            rs = 2'($urandom_range(0, 3));
            case ($urandom % 8)
                0: ra = $urandom;
                1: ra = 32'(MEMB - 4 + int'($urandom % 8));
                default: begin
                    ra = $urandom % MEMB;
                    if ($urandom % 4 != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
                end
            endcase
            txn(1'($urandom), 1'($urandom), rs, 1'($urandom), ra, $urandom,
                int'($urandom_range(0, 2)), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
